ext_pwr_gate_ctrl: RTL and testbench



---
 rtl/ext_pwr_gate_ctrl.sv | 235 +++++++++++++++++++++++
 tb/tb_ext_pwr_gate_ctrl.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/ext_pwr_gate_ctrl.sv
// Power-gating sequencer for one external-subsystem domain: orders isolation, domain
// reset and supply switching, waits for the switch-cell ack and flags ack timeouts.
module ext_pwr_gate_ctrl #(
   parameter int ISO_SETUP_CYCLES = 2,
   parameter int RST_HOLD_CYCLES  = 4,
   parameter int ACK_TIMEOUT      = 64
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic off_req_i,
   input  logic on_req_i,
   input  logic idle_i,
   input  logic switch_ack_i,
   input  logic clr_err_i,
   output logic switch_o,
   output logic iso_o,
   output logic subsys_rst_no,
   output logic busy_o,
   output logic done_o,
   output logic err_o
);

   localparam int MAX_SEQ = (ISO_SETUP_CYCLES > RST_HOLD_CYCLES) ? ISO_SETUP_CYCLES : RST_HOLD_CYCLES;
   localparam int MAX_ALL = (MAX_SEQ > ACK_TIMEOUT) ? MAX_SEQ : ACK_TIMEOUT;
   localparam int CNT_W   = $clog2(MAX_ALL + 1);

   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] ISO_LOAD = CNT_W'(ISO_SETUP_CYCLES - 1);
   localparam logic [CNT_W-1:0] RST_LOAD = CNT_W'(RST_HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] ACK_LOAD = CNT_W'(ACK_TIMEOUT - 1);

   typedef enum logic [3:0] {
      S_ON          = 4'd0,
      S_WAIT_IDLE   = 4'd1,
      S_ISO         = 4'd2,
      S_RST_ASSERT  = 4'd3,
      S_SW_OFF      = 4'd4,
      S_OFF         = 4'd5,
      S_SW_ON       = 4'd6,
      S_RST_RELEASE = 4'd7,
      S_ISO_RELEASE = 4'd8,
      S_FAULT       = 4'd9
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             switch_q, switch_d;
   logic             iso_q, iso_d;
   logic             rst_n_q, rst_n_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             err_q, err_d;

   logic             cnt_zero_s;
   logic             state_change_s;
   logic             timeout_set_s;
   logic [2:0]       pwr_vec_s;

   // {switch, iso, rst_n} for each state; unknown encodings get the clamped, unpowered set.
   function automatic logic [2:0] state_pwr(input state_t s);
      logic [2:0] v;
      case (s)
         S_ON:          v = 3'b101;
         S_WAIT_IDLE:   v = 3'b101;
         S_ISO:         v = 3'b111;
         S_RST_ASSERT:  v = 3'b110;
         S_SW_OFF:      v = 3'b010;
         S_OFF:         v = 3'b010;
         S_SW_ON:       v = 3'b110;
         S_RST_RELEASE: v = 3'b110;
         S_ISO_RELEASE: v = 3'b111;
         S_FAULT:       v = 3'b010;
         default:       v = 3'b010;
      endcase
      return v;
   endfunction

   function automatic logic state_busy(input state_t s);
      logic b;
      case (s)
         S_ON:    b = 1'b0;
         S_OFF:   b = 1'b0;
         S_FAULT: b = 1'b0;
         default: b = 1'b1;
      endcase
      return b;
   endfunction

   // Counter value loaded when a state is entered; it reaches zero on the state's last cycle.
   function automatic logic [CNT_W-1:0] entry_load(input state_t s);
      logic [CNT_W-1:0] l;
      case (s)
         S_ISO:         l = ISO_LOAD;
         S_RST_ASSERT:  l = RST_LOAD;
         S_SW_OFF:      l = ACK_LOAD;
         S_SW_ON:       l = ACK_LOAD;
         S_RST_RELEASE: l = RST_LOAD;
         S_ISO_RELEASE: l = ISO_LOAD;
         default:       l = CNT_ZERO;
      endcase
      return l;
   endfunction

   assign cnt_zero_s = (cnt_q == CNT_ZERO);

   // State register
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q <= S_ON;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic; an ack match on the final allowed cycle beats the timeout.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_ON: begin
            if (off_req_i) state_d = S_WAIT_IDLE;
            else           state_d = S_ON;
         end
         S_WAIT_IDLE: begin
            if (on_req_i)    state_d = S_ON;
            else if (idle_i) state_d = S_ISO;
            else             state_d = S_WAIT_IDLE;
         end
         S_ISO: begin
            if (cnt_zero_s) state_d = S_RST_ASSERT;
            else            state_d = S_ISO;
         end
         S_RST_ASSERT: begin
            if (cnt_zero_s) state_d = S_SW_OFF;
            else            state_d = S_RST_ASSERT;
         end
         S_SW_OFF: begin
            if (!switch_ack_i)   state_d = S_OFF;
            else if (cnt_zero_s) state_d = S_FAULT;
            else                 state_d = S_SW_OFF;
         end
         S_OFF: begin
            if (on_req_i) state_d = S_SW_ON;
            else          state_d = S_OFF;
         end
         S_SW_ON: begin
            if (switch_ack_i)    state_d = S_RST_RELEASE;
            else if (cnt_zero_s) state_d = S_FAULT;
            else                 state_d = S_SW_ON;
         end
         S_RST_RELEASE: begin
            if (cnt_zero_s) state_d = S_ISO_RELEASE;
            else            state_d = S_RST_RELEASE;
         end
         S_ISO_RELEASE: begin
            if (cnt_zero_s) state_d = S_ON;
            else            state_d = S_ISO_RELEASE;
         end
         S_FAULT: begin
            if (on_req_i) state_d = S_SW_ON;
            else          state_d = S_FAULT;
         end
         default: state_d = S_FAULT;
      endcase
   end

   // Shared down-counter: reload on every state change, otherwise count down to zero.
   always_comb begin
      state_change_s = (state_d != state_q);
      cnt_d          = cnt_q;
      if (state_change_s) begin
         cnt_d = entry_load(state_d);
      end else if (!cnt_zero_s) begin
         cnt_d = cnt_q - CNT_ONE;
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Counter register
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         cnt_q <= CNT_ZERO;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // Output decode from the next state so the registered outputs line up with the state.
   always_comb begin
      pwr_vec_s     = state_pwr(state_d);
      switch_d      = pwr_vec_s[2];
      iso_d         = pwr_vec_s[1];
      rst_n_d       = pwr_vec_s[0];
      busy_d        = state_busy(state_d);
      done_d        = ((state_q == S_SW_OFF) && (state_d == S_OFF)) ||
                      ((state_q == S_ISO_RELEASE) && (state_d == S_ON));
      timeout_set_s = (state_d == S_FAULT) &&
                      ((state_q == S_SW_OFF) || (state_q == S_SW_ON));
      if (timeout_set_s) begin
         err_d = 1'b1;
      end else if (clr_err_i) begin
         err_d = 1'b0;
      end else begin
         err_d = err_q;
      end
   end

   // Output registers
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         switch_q <= 1'b1;
         iso_q    <= 1'b0;
         rst_n_q  <= 1'b1;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         switch_q <= switch_d;
         iso_q    <= iso_d;
         rst_n_q  <= rst_n_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         err_q    <= err_d;
      end
   end

   assign switch_o      = switch_q;
   assign iso_o         = iso_q;
   assign subsys_rst_no = rst_n_q;
   assign busy_o        = busy_q;
   assign done_o        = done_q;
   assign err_o         = err_q;

endmodule

// File: tb/tb_ext_pwr_gate_ctrl.sv
// Directed bench for ext_pwr_gate_ctrl: expected output vectors are queued with the
// cycle they must appear in, and checked one cycle step at a time.
module tb_ext_pwr_gate_ctrl;

   logic clk = 1'b0;
   logic rst_ni, off_req_i, on_req_i, idle_i, switch_ack_i, clr_err_i;
   logic switch_o, iso_o, subsys_rst_no, busy_o, done_o, err_o;

   ext_pwr_gate_ctrl #(.ISO_SETUP_CYCLES(2), .RST_HOLD_CYCLES(4), .ACK_TIMEOUT(64)) dut (
      .clk_i(clk), .rst_ni(rst_ni), .off_req_i(off_req_i), .on_req_i(on_req_i),
      .idle_i(idle_i), .switch_ack_i(switch_ack_i), .clr_err_i(clr_err_i),
      .switch_o(switch_o), .iso_o(iso_o), .subsys_rst_no(subsys_rst_no),
      .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
   );

   always #5 clk = ~clk;

   // Vectors are {switch, iso, rst_n, busy, done, err}.
   localparam logic [5:0] V_ON       = 6'b101000;
   localparam logic [5:0] V_ON_DONE  = 6'b101010;
   localparam logic [5:0] V_WAIT     = 6'b101100;
   localparam logic [5:0] V_ISO      = 6'b111100;
   localparam logic [5:0] V_RSTA     = 6'b110100;
   localparam logic [5:0] V_SWOFF    = 6'b010100;
   localparam logic [5:0] V_OFF      = 6'b010000;
   localparam logic [5:0] V_OFF_DONE = 6'b010010;
   localparam logic [5:0] V_SWON     = 6'b110100;
   localparam logic [5:0] V_RSTR     = 6'b110100;
   localparam logic [5:0] V_ISOR     = 6'b111100;
   localparam logic [5:0] V_FAULT    = 6'b010000;
   localparam logic [5:0] V_FAULT_E  = 6'b010001;

   typedef struct {
      int         cyc;
      string      tag;
      logic [5:0] v;
   } exp_t;

   exp_t         sb[$];
   int           checks   = 0;
   int           failures = 0;
   int           cyc      = 0;
   int           lag      = 15;
   logic         stuck_en = 1'b0;
   logic [127:0] hist     = {128{1'b1}};
   int           t0, t1;

   function automatic void expect_at(input int c, input string tag, input logic [5:0] v);
      sb.push_back('{c, tag, v});
   endfunction

   // Advance one cycle, compare every expectation due now, then move the switch-cell model.
   task automatic tick();
      logic [5:0] obs;
      @(posedge clk);
      #1;
      cyc++;
      obs = {switch_o, iso_o, subsys_rst_no, busy_o, done_o, err_o};
      for (int i = sb.size() - 1; i >= 0; i--) begin
         if (sb[i].cyc <= cyc) begin
            checks++;
            assert (obs === sb[i].v && sb[i].cyc == cyc) else begin
               failures++;
               $error("FAIL %s @cycle %0d: observed=%b expected=%b (due %0d)",
                      sb[i].tag, cyc, obs, sb[i].v, sb[i].cyc);
            end
            sb.delete(i);
         end
      end
      hist = {hist[126:0], switch_o};
      switch_ack_i = stuck_en ? 1'b1 : hist[lag];
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   initial begin
      rst_ni = 1'b0; off_req_i = 1'b0; on_req_i = 1'b0; idle_i = 1'b1;
      clr_err_i = 1'b0; switch_ack_i = 1'b1;

      expect_at(2, "reset_state", V_ON);
      run(2);
      rst_ni = 1'b1;
      expect_at(3, "post_reset", V_ON);
      tick();

      // Power-off with ack lagging by 15 cycles.
      t0 = cyc; off_req_i = 1'b1;
      expect_at(t0 + 1,  "off_wait_idle", V_WAIT);
      expect_at(t0 + 2,  "off_iso_rise",  V_ISO);
      expect_at(t0 + 3,  "off_iso_hold",  V_ISO);
      expect_at(t0 + 4,  "off_rst_fall",  V_RSTA);
      expect_at(t0 + 7,  "off_rst_hold",  V_RSTA);
      expect_at(t0 + 8,  "off_sw_fall",   V_SWOFF);
      expect_at(t0 + 23, "off_ack_wait",  V_SWOFF);
      expect_at(t0 + 24, "off_done",      V_OFF_DONE);
      expect_at(t0 + 25, "off_done_end",  V_OFF);
      tick(); off_req_i = 1'b0;
      run(30);

      // Power-on from OFF, ack lag 15.
      t0 = cyc; on_req_i = 1'b1;
      expect_at(t0 + 1,  "on_sw_rise",    V_SWON);
      expect_at(t0 + 16, "on_ack_wait",   V_SWON);
      expect_at(t0 + 20, "on_rst_hold",   V_RSTR);
      expect_at(t0 + 21, "on_rst_rise",   V_ISOR);
      expect_at(t0 + 22, "on_iso_hold",   V_ISOR);
      expect_at(t0 + 23, "on_done",       V_ON_DONE);
      expect_at(t0 + 24, "on_done_end",   V_ON);
      tick(); on_req_i = 1'b0;
      run(25);

      // idle_i low for 30 cycles holds WAIT_IDLE.
      idle_i = 1'b0; t0 = cyc; off_req_i = 1'b1;
      expect_at(t0 + 1,  "idle_wait_a", V_WAIT);
      expect_at(t0 + 15, "idle_wait_b", V_WAIT);
      expect_at(t0 + 30, "idle_wait_c", V_WAIT);
      expect_at(t0 + 31, "idle_iso",    V_ISO);
      expect_at(t0 + 53, "idle_off",    V_OFF_DONE);
      tick(); off_req_i = 1'b0;
      run(29);
      idle_i = 1'b1;
      run(25);
      t0 = cyc; on_req_i = 1'b1;
      expect_at(t0 + 23, "idle_on_done", V_ON_DONE);
      tick(); on_req_i = 1'b0;
      run(25);

      // Abort from WAIT_IDLE, on_req_i beating a simultaneous idle_i.
      t0 = cyc; off_req_i = 1'b1; idle_i = 1'b0;
      expect_at(t0 + 1, "abort_wait", V_WAIT);
      tick(); off_req_i = 1'b0; on_req_i = 1'b1; idle_i = 1'b1;
      expect_at(t0 + 2, "abort_on",   V_ON);
      expect_at(t0 + 3, "abort_stay", V_ON);
      tick(); on_req_i = 1'b0;
      run(70);

      // Ack arriving on the last allowed cycle wins over the timeout.
      lag = 63;
      t0 = cyc; off_req_i = 1'b1;
      expect_at(t0 + 71, "last_off_wait", V_SWOFF);
      expect_at(t0 + 72, "last_off_done", V_OFF_DONE);
      tick(); off_req_i = 1'b0;
      run(71);
      t1 = cyc; on_req_i = 1'b1;
      expect_at(t1 + 64, "last_on_wait", V_SWON);
      expect_at(t1 + 65, "last_on_ack",  V_RSTR);
      expect_at(t1 + 69, "last_on_iso",  V_ISOR);
      expect_at(t1 + 71, "last_on_done", V_ON_DONE);
      tick(); on_req_i = 1'b0;
      run(72);
      lag = 15;
      run(20);

      // Ack stuck high in SW_OFF; clear held high so set-wins and clear are both seen.
      stuck_en = 1'b1; clr_err_i = 1'b1;
      t0 = cyc; off_req_i = 1'b1;
      expect_at(t0 + 71, "stuck_last",  V_SWOFF);
      expect_at(t0 + 72, "stuck_fault", V_FAULT_E);
      expect_at(t0 + 73, "stuck_clear", V_FAULT);
      tick(); off_req_i = 1'b0;
      run(72);
      clr_err_i = 1'b0; stuck_en = 1'b0;
      t1 = cyc; on_req_i = 1'b1;
      expect_at(t1 + 1,  "fault_on_sw",   V_SWON);
      expect_at(t1 + 23, "fault_on_done", V_ON_DONE);
      tick(); on_req_i = 1'b0;
      run(25);

      // Reset pulse in SW_OFF, then both requests high in OFF.
      t0 = cyc; off_req_i = 1'b1;
      expect_at(t0 + 10, "rst_in_swoff", V_SWOFF);
      expect_at(t0 + 11, "rst_on_vals",  V_ON);
      expect_at(t0 + 12, "rst_stay_on",  V_ON);
      tick(); off_req_i = 1'b0;
      run(9);
      rst_ni = 1'b0;
      tick(); rst_ni = 1'b1;
      run(30);
      t0 = cyc; off_req_i = 1'b1;
      expect_at(t0 + 24, "both_pre_off", V_OFF_DONE);
      tick(); off_req_i = 1'b0;
      run(24);
      off_req_i = 1'b1; on_req_i = 1'b1; t1 = cyc;
      expect_at(t1 + 1,  "both_on_start", V_SWON);
      expect_at(t1 + 2,  "both_on_hold",  V_SWON);
      expect_at(t1 + 23, "both_on_done",  V_ON_DONE);
      tick(); off_req_i = 1'b0; on_req_i = 1'b0;
      run(25);

      checks++;
      assert (sb.size() == 0) else begin
         failures++;
         $error("FAIL scoreboard_drain: observed=%0d pending expected=0", sb.size());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
